// File: rtl/types_pkg.sv
// Shared types for the instruction path: machine-word bus, decoded opcode
// classes, encoder FSM states and the RV32I field constants the encoder emits.
package types_pkg;

    typedef logic [31:0] DATA_BUS;

    // Two-bit opcode class; encodings 2 and 3 are deliberately unassigned (illegal).
    typedef enum logic [1:0] {
        OP_ADDI = 2'd0,
        OP_BNE  = 2'd1
    } opcode;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } encoder_state;

    localparam logic [2:0] F3_ADDI    = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I packer for the addi/bne subset; flags requests that
// cannot be encoded (unknown opcode, out-of-range or misaligned immediate).
module instr_pack
    import types_pkg::*;
(
    input  opcode       op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [12:0] imm,
    output DATA_BUS     word,
    output logic        legal
);

    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (op)
            OP_ADDI: begin
                // 13-bit value fits in 12 signed bits only if the top two bits agree
                legal = (imm[12] == imm[11]);
                word  = {imm[11:0], rs1, F3_ADDI, rd, OPC_OP_IMM};
            end
            OP_BNE: begin
                legal = ~imm[0];
                word  = {imm[12], imm[10:5], rs2, rs1, F3_BNE, imm[4:1], imm[11], OPC_BRANCH};
            end
            default: begin
                word  = '0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Sequential program loader: packs accepted requests and writes them to
// consecutive instruction-memory words starting at BASE_ADDR.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready
// and start is low; req_valid may not be withdrawn by the encoder, and
// req_ready depends only on registered state, never on req_valid.
module instr_encoder
    import types_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          DEPTH     = 64,
    localparam int         CW        = $clog2(DEPTH) + 1
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          req_valid,
    output logic          req_ready,
    input  opcode         req_op,
    input  logic [4:0]    req_rd,
    input  logic [4:0]    req_rs1,
    input  logic [4:0]    req_rs2,
    input  logic [12:0]   req_imm,
    input  logic          req_last,
    output logic          mem_we,
    output DATA_BUS       mem_addr,
    output DATA_BUS       mem_wdata,
    output logic          done,
    output logic          full,
    output logic          err,
    output logic [CW-1:0] count,
    output logic [1:0]    dbg_state
);

    encoder_state state_q;
    DATA_BUS      pack_word;
    logic         pack_legal;
    logic         accept;
    logic         at_last_slot;

    instr_pack u_pack (
        .op    (req_op),
        .rd    (req_rd),
        .rs1   (req_rs1),
        .rs2   (req_rs2),
        .imm   (req_imm),
        .word  (pack_word),
        .legal (pack_legal)
    );

    assign req_ready    = (state_q == ST_LOAD);
    assign dbg_state    = state_q;
    assign accept       = req_valid && req_ready && !start;
    assign at_last_slot = (count == CW'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            full      <= 1'b0;
            err       <= 1'b0;
            count     <= '0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            if (start) begin
                state_q <= ST_LOAD;
                full    <= 1'b0;
                err     <= 1'b0;
                count   <= '0;
            end else if (accept) begin
                if (pack_legal) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= BASE_ADDR + (DATA_BUS'(count) << 2);
                    mem_wdata <= pack_word;
                    count     <= count + CW'(1);
                    if (at_last_slot) begin
                        full <= 1'b1;
                    end
                end else begin
                    err <= 1'b1;
                end
                // last wins over full: a program that exactly fills memory still ends in IDLE
                if (req_last) begin
                    state_q <= ST_IDLE;
                    done    <= 1'b1;
                end else if (pack_legal && at_last_slot) begin
                    state_q <= ST_FULL;
                end
            end
        end
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential instruction encoder and program loader: accepts decoded instruction requests (opcode, register indices, immediate) over a valid/ready handshake, packs them into 32-bit RV32I machine words, and writes them sequentially into instruction memory. It is the producer end of the instruction path whose consumer is the control unit. It is used by the testbench and boot path to build programs in instruction memory without hand-assembled hex. Supported opcodes match the decoder: `addi` and `bne`.

## Interface
- `BASE_ADDR`, default 32'h0: byte address of the first instruction written after `start`.
- `DEPTH`, default 64: capacity in 32-bit words.
- `clk`  in  1  clock. Everything is sampled on the rising edge.
- `rst`  in  1  reset. Synchronous and active-high.
- `start`  in  1  single-cycle pulse. Clears the write pointer and begins a load.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  encoder can accept a request.
- `req_op`  in  `opcode`  instruction class (`addi`, `bne`; any other value is illegal).
- `req_rd`, `req_rs1`, `req_rs2`  in  5 each  register indices. `rd` is ignored for `bne`; `rs2` is ignored for `addi`.
- `req_imm`  in  13  signed immediate. `addi` uses bits [11:0]; `bne` uses bits [12:1].
- `req_last`  in  1  this request ends the program.
- `mem_we`  out  1  instruction-memory write strobe.
- `mem_addr`  out  `DATA_BUS`  byte address.
- `mem_wdata`  out  `DATA_BUS`  encoded instruction.
- `done`  out  1  single-cycle pulse after the last word is written.
- `full`  out  1  level; capacity is exhausted.
- `err`  out  1  sticky illegal-request flag. Cleared by `rst` or `start`.
- `count`  out  `$clog2(DEPTH)+1`  number of words written since `start`.

## Operation
- States:
  - IDLE: after reset. `req_ready` is 0.
  - LOAD: `req_ready` is 1.
  - FULL: `req_ready` is 0 and `full` is 1.
- Transitions:
  - `start` in any state goes to LOAD, clears the write pointer, `count` and `err`. `start` has priority over a request in the same cycle; that request is not accepted.
  - An accepted request with `req_last` goes to IDLE.
  - An accepted request that writes word index DEPTH-1 without `req_last` goes to FULL.
  - FULL leaves only on `start` or `rst`.
- A request is accepted when `req_valid && req_ready`.
- Encoding:
  - `addi`: {imm[11:0], rs1, 3'b000, rd, 7'b0010011}.
  - `bne`: {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], 7'b1100011}.
- Illegal requests (unsupported opcode, `addi` with imm not in −2048..2047, `bne` with imm[0]=1):
  - Set `err`.
  - Nothing is written and the pointer does not advance.
  - The request is still accepted, and `req_last` on it still applies.
- Address: `mem_addr` = BASE_ADDR + 4·pointer, mod 2^32.

## Timing
- Reset values:
  - State is IDLE.
  - `req_ready`, `mem_we`, `done`, `full` and `err` are 0.
  - `mem_addr`, `mem_wdata` and `count` are 0.
- Latency is one cycle. A request accepted at edge N produces `mem_we`=1 with `mem_addr`/`mem_wdata` registered, valid during cycle N+1. `count` increments at the same edge.
- Throughput is one request per cycle, back-to-back.
- `req_ready` is a registered state decode. It deasserts in the cycle after the accepting edge that ends LOAD (last or full).
- `done` pulses in the same cycle as the final `mem_we`. If the last request is illegal, `done` pulses with `mem_we`=0.
- `full` asserts in the same cycle as the DEPTH-th `mem_we`.
- `start` while a write is registered: that write still appears in the following cycle, then the next load begins at BASE_ADDR.
- `rst` mid-load: all outputs return to reset values at the next edge, and any registered write is dropped.
- `mem_wdata`/`mem_addr` hold their last value when `mem_we`=0.

## Structure
- In `types_pkg`:
  - Add an `encoder_state` enum (IDLE/LOAD/FULL).
  - Add the funct3 constants `F3_ADDI`=3'b000 and `F3_BNE`=3'b001.
  - Reuse the existing `opcode` and `DATA_BUS` types.
- One natural sub-module, `instr_pack`: combinational. Inputs are op, regs and imm; outputs are word and legal. It is reusable by benches as a golden model.
- The top level holds the FSM, pointer and output register.

## Test plan
- Reset; `start`; request addi rd=1 rs1=0 imm=5, last=1 -> next cycle `mem_we`=1, addr 0x0, wdata 0x00500093, `done`=1, `count`=1, then IDLE with `req_ready`=0.
- Back-to-back: addi x5,x5,−1, then bne rs1=1 rs2=2 imm=−8 with last -> consecutive writes 0xFFF28293 @0x0 and 0xFE209CE3 @0x4, `done` with the second.
- DEPTH=4, five valid requests, no last -> four writes @0x0–0xC, `full`=1 with the fourth, `req_ready`=0, fifth request not accepted.
- bne imm=3 (odd) between two legal addis -> `err`=1, no write for it, the second addi lands at 0x4, `count`=2.
- Illegal opcode with last -> `err`=1, `done` pulses, `mem_we`=0.
- `start` mid-load after 3 writes (one write registered) -> pending write emitted at 0x8, next accepted request written at 0x0, `count` restarts, `err` cleared. `rst` at the same point -> `mem_we`=0 next cycle and all outputs 0.
